// File: rtl/lcd_pkg.sv
// Shared timing defaults, FSM state encoding and command helpers for the
// character-LCD bus scheduler.
package lcd_pkg;

    localparam int T_SETUP_DEF = 8;
    localparam int T_EHIGH_DEF = 50;
    localparam int T_HOLD_DEF  = 4;
    localparam int T_GAP_DEF   = 200;
    localparam int T_WAIT_DEF  = 8000;
    localparam int T_LONG_DEF  = 328000;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SETUP_H = 4'd1,
        ST_EHI_H   = 4'd2,
        ST_HOLD_H  = 4'd3,
        ST_GAP     = 4'd4,
        ST_SETUP_L = 4'd5,
        ST_EHI_L   = 4'd6,
        ST_HOLD_L  = 4'd7,
        ST_WAIT    = 4'd8
    } lcd_state_t;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the
// winner whenever the grant is consumed (advance strobe).
module lcd_rr_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic [N_REQ-1:0] o_grant
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_found;

    // First pass covers indices at/above the pointer, second pass wraps around.
    always_comb begin
        o_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req[i] && (i >= int'(r_ptr))) begin
                w_found    = 1'b1;
                o_grant[i] = 1'b1;
                w_win      = PW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req[i] && (i < int'(r_ptr))) begin
                w_found    = 1'b1;
                o_grant[i] = 1'b1;
                w_win      = PW'(i);
            end
        end
    end

    always_comb begin
        w_ptr_nxt = '0;
        if (int'(w_win) != N_REQ - 1) begin
            w_ptr_nxt = w_win + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares the 4-bit HD44780 LCD bus between N_REQ requesters; one byte write
// (two nibble strobes plus execution wait) per round-robin grant.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_EHIGH = T_EHIGH_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int T_WAIT  = T_WAIT_DEF,
    parameter int T_LONG  = T_LONG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_rs,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic [3:0]         lcd_data,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic [3:0]         dbg_state
);

    // Handshake: req with rs/data held stable until a one-cycle ack; ack marks the
    // capture edge, and req still high in the ack cycle counts as the next request.

    localparam int CW = $clog2(max_of3(T_WAIT, T_LONG, T_GAP) + 1);

    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_EHIGH = CW'(T_EHIGH - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_GAP   = CW'(T_GAP - 1);
    localparam logic [CW-1:0] C_WAIT  = CW'(T_WAIT - 1);
    localparam logic [CW-1:0] C_LONG  = CW'(T_LONG - 1);

    lcd_state_t       r_state;
    lcd_state_t       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_rs;
    logic [7:0]       r_data;
    logic [N_REQ-1:0] r_ack;
    logic             r_busy;
    logic [3:0]       r_lcd_data;
    logic             r_lcd_e;
    logic             r_lcd_rs;

    logic [N_REQ-1:0] w_grant;
    logic             w_advance;
    logic             w_sel_rs;
    logic [7:0]       w_sel_data;
    logic             w_rs_nxt;
    logic [7:0]       w_data_nxt;
    logic [3:0]       w_lcd_data_nxt;
    logic             w_lcd_rs_nxt;

    lcd_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_advance (w_advance),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_sel_rs   = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rs   = req_rs[i];
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Each timed state loads (T-1) on entry and leaves when the counter hits zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - CW'(1);
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (|req) begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_SETUP_H;
                    w_cnt_nxt   = C_SETUP;
                end
            end
            ST_SETUP_H: if (r_cnt == '0) begin w_state_nxt = ST_EHI_H;   w_cnt_nxt = C_EHIGH; end
            ST_EHI_H:   if (r_cnt == '0) begin w_state_nxt = ST_HOLD_H;  w_cnt_nxt = C_HOLD;  end
            ST_HOLD_H:  if (r_cnt == '0) begin w_state_nxt = ST_GAP;     w_cnt_nxt = C_GAP;   end
            ST_GAP:     if (r_cnt == '0) begin w_state_nxt = ST_SETUP_L; w_cnt_nxt = C_SETUP; end
            ST_SETUP_L: if (r_cnt == '0) begin w_state_nxt = ST_EHI_L;   w_cnt_nxt = C_EHIGH; end
            ST_EHI_L:   if (r_cnt == '0) begin w_state_nxt = ST_HOLD_L;  w_cnt_nxt = C_HOLD;  end
            ST_HOLD_L: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = is_long_cmd(r_rs, r_data) ? C_LONG : C_WAIT;
                end
            end
            ST_WAIT:    if (r_cnt == '0) begin w_state_nxt = ST_IDLE;    w_cnt_nxt = '0;      end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pin values are derived from the next state so the pins change on the
    // same edge as the state, keeping every output a plain register.
    always_comb begin
        w_rs_nxt       = w_advance ? w_sel_rs   : r_rs;
        w_data_nxt     = w_advance ? w_sel_data : r_data;
        w_lcd_data_nxt = r_lcd_data;
        w_lcd_rs_nxt   = r_lcd_rs;
        if (w_state_nxt == ST_SETUP_H) begin
            w_lcd_data_nxt = w_data_nxt[7:4];
            w_lcd_rs_nxt   = w_rs_nxt;
        end else if (w_state_nxt == ST_SETUP_L) begin
            w_lcd_data_nxt = w_data_nxt[3:0];
            w_lcd_rs_nxt   = w_rs_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs       <= 1'b0;
            r_data     <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_lcd_data <= '0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
        end else begin
            r_rs       <= w_rs_nxt;
            r_data     <= w_data_nxt;
            r_ack      <= w_advance ? w_grant : '0;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_lcd_data <= w_lcd_data_nxt;
            r_lcd_e    <= (w_state_nxt == ST_EHI_H) || (w_state_nxt == ST_EHI_L);
            r_lcd_rs   <= w_lcd_rs_nxt;
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign lcd_data  = r_lcd_data;
    assign lcd_e     = r_lcd_e;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_rw    = 1'b0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: randomized byte writes against a
// transaction-level model of arbitration order, pin timing and busy length.
module tb_lcd_bus_scheduler;

    localparam int N_REQ   = 2;
    localparam int T_SETUP = 2;
    localparam int T_EHIGH = 4;
    localparam int T_HOLD  = 2;
    localparam int T_GAP   = 3;
    localparam int T_WAIT  = 10;
    localparam int T_LONG  = 50;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   req_rs;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               busy;
    logic [3:0]         lcd_data;
    logic               lcd_e;
    logic               lcd_rs;
    logic               lcd_rw;
    logic [3:0]         dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int         m_last;
    int         idle_cyc;
    int         raise_cyc;
    logic       m_rs   [N_REQ];
    logic [7:0] m_data [N_REQ];
    logic [31:0] exp_q [$];

    lcd_bus_scheduler #(
        .N_REQ(N_REQ), .T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH), .T_HOLD(T_HOLD),
        .T_GAP(T_GAP), .T_WAIT(T_WAIT), .T_LONG(T_LONG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .ack       (ack),
        .busy      (busy),
        .lcd_data  (lcd_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int txn_len(input logic rs, input logic [7:0] d);
        int w;
        w = (!rs && d >= 8'h01 && d <= 8'h03) ? T_LONG : T_WAIT;
        return 2 * (T_SETUP + T_EHIGH + T_HOLD) + T_GAP + w;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
        logic [N_REQ-1:0] sh;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (last + k) % N_REQ;
            sh  = r >> idx;
            if (sh[0]) return idx;
        end
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic raise(input int i, input logic rs, input logic [7:0] d);
        req_rs[i]         = rs;
        req_data[8*i +: 8] = d;
        req[i]            = 1'b1;
        m_rs[i]           = rs;
        m_data[i]         = d;
        raise_cyc         = cyc;
    endtask

    task automatic raise_random(input int i);
        logic       rs;
        logic [7:0] d;
        if ($urandom_range(0, 3) == 0) begin
            rs = 1'b0;
            d  = 8'($urandom_range(1, 3));
        end else begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
        end
        raise(i, rs, d);
    endtask

    task automatic wait_ack(output int who, output int at);
        who = -1;
        at  = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                at = cyc;
                for (int j = 0; j < N_REQ; j++) if (ack[j]) who = j;
                check("ack_onehot", 32'($countones(ack)), 32'd1);
                break;
            end
        end
    endtask

    // Called at the sample point of the ack cycle; returns at the IDLE cycle.
    task automatic observe(input logic rs, input logic [7:0] d);
        int len, blen, rises, r1, r2, hi, extra, rs_bad;
        logic prev_e;
        logic [3:0] n1, n2;
        len = txn_len(rs, d);
        blen = 0; rises = 0; r1 = -1; r2 = -1; hi = 0; extra = 0; rs_bad = 0;
        prev_e = 1'b0; n1 = '0; n2 = '0;
        for (int t = 0; t < len + 10; t++) begin
            if (t > 0) @(negedge clk);
            if (!busy) break;
            blen++;
            if (t > 0 && ack != '0) extra++;
            if (lcd_rs !== rs || lcd_rw !== 1'b0) rs_bad++;
            if (lcd_e) hi++;
            if (lcd_e && !prev_e) begin
                rises++;
                if (rises == 1) begin r1 = t; n1 = lcd_data; end
                if (rises == 2) begin r2 = t; n2 = lcd_data; end
            end
            prev_e = lcd_e;
        end
        idle_cyc = cyc;
        check("busy_len",   32'(blen),    32'(len));
        check("e_pulses",   32'(rises),   32'd2);
        check("e_high_cyc", 32'(hi),      32'(2 * T_EHIGH));
        check("e_rise1",    32'(r1),      32'(T_SETUP));
        check("e_rise_gap", 32'(r2 - r1), 32'(T_EHIGH + T_HOLD + T_GAP + T_SETUP));
        check("nibble_hi",  32'(n1),      32'(d[7:4]));
        check("nibble_lo",  32'(n2),      32'(d[3:0]));
        check("rs_rw_hold", 32'(rs_bad),  32'd0);
        check("extra_ack",  32'(extra),   32'd0);
        check("e_idle",     32'(lcd_e),   32'd0);
    endtask

    task automatic serve(input logic [N_REQ-1:0] hold);
        int who, at, pick, t0;
        pick = rr_pick(req, m_last);
        exp_q.push_back(32'(pick));
        t0 = (raise_cyc > idle_cyc) ? raise_cyc : idle_cyc;
        wait_ack(who, at);
        check("ack_winner",  32'(who), exp_q.pop_front());
        check("ack_latency", 32'(at),  32'(t0 + 1));
        if (who < 0) return;
        m_last = who;
        if (!hold[who]) req[who] = 1'b0;
        observe(m_rs[who], m_data[who]);
    endtask

    task automatic reset_mid_write(input int first);
        int who, at, rises;
        logic prev_e;
        raise(first, 1'b1, 8'($urandom_range(0, 255)));
        wait_ack(who, at);
        check("rst_pre_ack", 32'(who), 32'(first));
        req[first] = 1'b0;
        rises  = 0;
        prev_e = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (lcd_e && !prev_e) rises++;
            prev_e = lcd_e;
            if (rises == 2) break;
        end
        check("rst_at_ehi_l", 32'(rises), 32'd2);
        rst = 1'b1;
        #1;
        check("rst_async_e",    32'(lcd_e),    32'd0);
        check("rst_async_busy", 32'(busy),     32'd0);
        check("rst_async_ack",  32'(ack),      32'd0);
        check("rst_async_data", 32'(lcd_data), 32'd0);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        m_last   = N_REQ - 1;
        idle_cyc = cyc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e_cnt, b_cnt, a_cnt;
        logic [N_REQ-1:0] mask;

        rst = 1'b1; req = '0; req_rs = '0; req_data = '0;
        m_last = N_REQ - 1; idle_cyc = 0; raise_cyc = 0;

        repeat (50) @(negedge clk);
        check("rst_ack",  32'(ack),      32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_e",    32'(lcd_e),    32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);
        check("rst_rs",   32'(lcd_rs),   32'd0);
        check("rst_rw",   32'(lcd_rw),   32'd0);
        repeat (50) @(negedge clk);
        rst = 1'b0;
        idle_cyc = cyc;

        e_cnt = 0; b_cnt = 0; a_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            e_cnt += int'(lcd_e);
            b_cnt += int'(busy);
            a_cnt += (ack != '0) ? 1 : 0;
        end
        check("idle_e",    32'(e_cnt),    32'd0);
        check("idle_busy", 32'(b_cnt),    32'd0);
        check("idle_ack",  32'(a_cnt),    32'd0);
        check("idle_data", 32'(lcd_data), 32'd0);

        // single data byte, then a clear-display command
        raise(0, 1'b1, 8'h41);
        serve('0);
        raise(1, 1'b0, 8'h01);
        serve('0);

        // random masks, random gaps, random bytes
        for (int it = 0; it < 12; it++) begin
            if (req == '0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
                for (int i = 0; i < N_REQ; i++) if (mask[i]) raise_random(i);
            end
            serve('0);
        end
        for (int i = 0; i < N_REQ && req != '0; i++) serve('0);

        // both requesters held continuously
        raise(0, 1'b1, 8'($urandom_range(0, 255)));
        raise(1, 1'b1, 8'($urandom_range(0, 255)));
        repeat (4) serve('1);
        req = '0;

        // new request raised in the cycle busy falls, then no stray ack
        raise_random(0);
        serve('0);
        raise_random(1);
        serve('0);
        a_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            a_cnt += (ack != '0) ? 1 : 0;
        end
        check("no_double_ack", 32'(a_cnt), 32'd0);
        idle_cyc = cyc;

        // reset during EHI_L, then requester 1 alone
        reset_mid_write(0);
        raise(1, 1'b0, 8'h28);
        serve('0);

        // reset during EHI_L, then both: pointer must be back at 0
        reset_mid_write(0);
        raise_random(0);
        raise_random(1);
        serve('0);
        serve('0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
